width_reassembler: RTL and testbench



---
 rtl/width_conv_pkg.sv | 12 +
 rtl/width_reasm_slot.sv | 35 +++
 rtl/width_reassembler.sv | 99 +++++++++
 tb/tb_width_reassembler.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/width_conv_pkg.sv
// Shared sizing helpers for the narrow-link width converters (serializer and reassembler sides).
package width_conv_pkg;

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/width_reasm_slot.sv
// One-entry word+count holding register with valid/ready on both sides; the reassembler's output stage.
module width_reasm_slot #(
  parameter int WORD_WIDTH = 10,
  parameter int CNT_W      = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_valid,
  input  logic [WORD_WIDTH-1:0] load_word,
  input  logic [CNT_W-1:0]      load_count,
  output logic                  load_ready,
  output logic                  valid,
  output logic [WORD_WIDTH-1:0] word,
  output logic [CNT_W-1:0]      count,
  input  logic                  ready
);

  // Slot is free when empty or being drained this cycle.
  assign load_ready = !valid || ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      word  <= '0;
      count <= '0;
    end else if (load_ready) begin
      valid <= load_valid;
      if (load_valid) begin
        word  <= load_word;
        count <= load_count;
      end
    end
  end

endmodule

// File: rtl/width_reassembler.sv
// Serial-to-parallel receiver: packs LSB-first CHUNK_WIDTH beats into WORD_WIDTH words, with early-last support.
module width_reassembler
  import width_conv_pkg::*;
#(
  parameter int WORD_WIDTH  = 10,
  parameter int CHUNK_WIDTH = 2,
  localparam int NUM_CHUNKS = ceil_div(WORD_WIDTH, CHUNK_WIDTH),
  localparam int CNT_W      = cnt_width(NUM_CHUNKS)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   valid_in,
  input  logic [CHUNK_WIDTH-1:0] chunk_in,
  input  logic                   last_in,
  output logic                   ready_in,
  output logic                   valid_out,
  output logic [WORD_WIDTH-1:0]  word_out,
  output logic [CNT_W-1:0]       count_out,
  input  logic                   ready_out
);

  localparam int BUF_W = NUM_CHUNKS * CHUNK_WIDTH;

  if (WORD_WIDTH <= CHUNK_WIDTH) begin : g_bad_widths
    $error("width_reassembler: WORD_WIDTH must exceed CHUNK_WIDTH");
  end

  logic [BUF_W-1:0]      asm_buf;
  logic [BUF_W-1:0]      next_buf;
  logic [CNT_W-1:0]      asm_cnt;
  logic [CNT_W-1:0]      comp_cnt;
  logic                  asm_full;
  logic                  accept;
  logic                  complete;
  logic                  slot_load;
  logic                  slot_ready;
  logic [WORD_WIDTH-1:0] slot_word;
  logic [CNT_W-1:0]      slot_cnt;

  // Buffer padded to whole chunks; the top chunk's excess bits are dropped when the word is taken.
  always_comb begin
    next_buf = asm_buf;
    for (int unsigned i = 0; i < NUM_CHUNKS; i++) begin
      if (asm_cnt == CNT_W'(i)) begin
        next_buf[i*CHUNK_WIDTH +: CHUNK_WIDTH] = chunk_in;
      end
    end
  end

  assign ready_in  = !asm_full;
  assign accept    = valid_in && !asm_full;
  assign comp_cnt  = asm_cnt + CNT_W'(1);
  assign complete  = accept && (last_in || (asm_cnt == CNT_W'(NUM_CHUNKS - 1)));

  // A held word always goes first; no beat is accepted while one is held, so the two never collide.
  assign slot_load = asm_full || complete;
  assign slot_word = asm_full ? asm_buf[WORD_WIDTH-1:0] : next_buf[WORD_WIDTH-1:0];
  assign slot_cnt  = asm_full ? asm_cnt : comp_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      asm_buf  <= '0;
      asm_cnt  <= '0;
      asm_full <= 1'b0;
    end else if (asm_full) begin
      if (slot_ready) begin
        asm_buf  <= '0;
        asm_cnt  <= '0;
        asm_full <= 1'b0;
      end
    end else if (accept) begin
      if (complete && slot_ready) begin
        asm_buf <= '0;
        asm_cnt <= '0;
      end else begin
        asm_buf  <= next_buf;
        asm_cnt  <= comp_cnt;
        asm_full <= complete;
      end
    end
  end

  width_reasm_slot #(
    .WORD_WIDTH (WORD_WIDTH),
    .CNT_W      (CNT_W)
  ) u_slot (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_valid (slot_load),
    .load_word  (slot_word),
    .load_count (slot_cnt),
    .load_ready (slot_ready),
    .valid      (valid_out),
    .word       (word_out),
    .count      (count_out),
    .ready      (ready_out)
  );

endmodule

// File: tb/tb_width_reassembler.sv
// Bench for width_reassembler: queue-based word model checked every cycle plus directed literal vectors.
module tb_width_reassembler;

  localparam int WW = 10;
  localparam int CW = 2;
  localparam int NC = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          valid_in = 1'b0;
  logic [CW-1:0] chunk_in = '0;
  logic          last_in = 1'b0;
  logic          ready_in;
  logic          valid_out;
  logic [WW-1:0] word_out;
  logic [2:0]    count_out;
  logic          ready_out = 1'b1;

  logic       v7 = 1'b0;
  logic [2:0] c7 = '0;
  logic       l7 = 1'b0;
  logic       ri7;
  logic       vo7;
  logic [6:0] wo7;
  logic [1:0] co7;
  logic       ro7 = 1'b1;

  int compared = 0;
  int mismatched = 0;
  int tp_stalls = 0;
  logic tp_phase = 1'b0;

  typedef struct {
    logic [31:0] word;
    logic [31:0] cnt;
  } wexp_t;
  wexp_t       q[$];
  logic [63:0] part_word = '0;
  int          part_len = 0;

  always #5 clk = ~clk;

  width_reassembler #(.WORD_WIDTH(WW), .CHUNK_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .chunk_in(chunk_in), .last_in(last_in),
    .ready_in(ready_in), .valid_out(valid_out), .word_out(word_out), .count_out(count_out),
    .ready_out(ready_out)
  );

  width_reassembler #(.WORD_WIDTH(7), .CHUNK_WIDTH(3)) dut7 (
    .clk(clk), .rst_n(rst_n), .valid_in(v7), .chunk_in(c7), .last_in(l7),
    .ready_in(ri7), .valid_out(vo7), .word_out(wo7), .count_out(co7), .ready_out(ro7)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a word is pending from its completing beat until its output handshake.
  // At most two can be pending (output slot + assembly slot).
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      part_word = '0;
      part_len = 0;
    end else begin
      check("ready_in", {31'b0, ready_in}, {31'b0, (q.size() < 2)});
      check("valid_out", {31'b0, valid_out}, {31'b0, (q.size() > 0)});
      if (valid_out && q.size() > 0) begin
        check("word_out", 32'(word_out), q[0].word);
        check("count_out", 32'(count_out), q[0].cnt);
        if (ready_out) void'(q.pop_front());
      end
      if (valid_in && ready_in) begin
        part_word = part_word | (64'(chunk_in) << (part_len * CW));
        part_len++;
        if (last_in || part_len == NC) begin
          q.push_back('{word: 32'(part_word & ((64'd1 << WW) - 1)), cnt: 32'(part_len)});
          part_word = '0;
          part_len = 0;
        end
      end
      if (tp_phase && !ready_in) tp_stalls++;
    end
  end

  task automatic beat(input logic [CW-1:0] c, input logic l);
    int n = 0;
    valid_in = 1'b1;
    chunk_in = c;
    last_in  = l;
    @(negedge clk);
    while (!ready_in && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!ready_in) check("beat_timeout", {31'b0, ready_in}, 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    valid_in = 1'b0;
    last_in  = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic beat7(input logic [2:0] c);
    int n = 0;
    v7 = 1'b1;
    c7 = c;
    @(negedge clk);
    while (!ri7 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!ri7) check("beat7_timeout", {31'b0, ri7}, 32'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [CW-1:0] basic [5];
    basic[0] = 2'h1; basic[1] = 2'h2; basic[2] = 2'h3; basic[3] = 2'h0; basic[4] = 2'h2;

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_valid_out", {31'b0, valid_out}, 32'd0);
    check("rst_word_out", 32'(word_out), 32'd0);
    check("rst_count_out", 32'(count_out), 32'd0);
    check("rst_ready_in", {31'b0, ready_in}, 32'd1);
    @(posedge clk); #1;

    // basic word
    for (int i = 0; i < 5; i++) beat(basic[i], 1'b0);
    valid_in = 1'b0;
    @(negedge clk);
    check("basic_valid", {31'b0, valid_out}, 32'd1);
    check("basic_word", 32'(word_out), 32'h239);
    check("basic_count", 32'(count_out), 32'd5);
    @(posedge clk); #1;

    // early last, then next word restarts at position 0
    beat(2'h3, 1'b0);
    beat(2'h1, 1'b1);
    valid_in = 1'b0; last_in = 1'b0;
    @(negedge clk);
    check("early_word", 32'(word_out), 32'h007);
    check("early_count", 32'(count_out), 32'd2);
    @(posedge clk); #1;
    beat(2'h2, 1'b1);
    valid_in = 1'b0; last_in = 1'b0;
    @(negedge clk);
    check("restart_word", 32'(word_out), 32'h002);
    check("restart_count", 32'(count_out), 32'd1);
    @(posedge clk); #1;

    // backpressure: A held on output, B held in assembly
    ready_out = 1'b0;
    for (int i = 0; i < 5; i++) beat(2'h1, 1'b0);
    for (int i = 0; i < 5; i++) beat(2'h2, 1'b0);
    valid_in = 1'b0;
    @(negedge clk);
    check("bp_ready_in_low", {31'b0, ready_in}, 32'd0);
    check("bp_word_a", 32'(word_out), 32'h155);
    @(posedge clk); #1;
    ready_out = 1'b1;
    @(negedge clk);
    check("bp_word_a_hs", 32'(word_out), 32'h155);
    check("bp_ready_in_still_low", {31'b0, ready_in}, 32'd0);
    @(negedge clk);
    check("bp_valid_b", {31'b0, valid_out}, 32'd1);
    check("bp_word_b", 32'(word_out), 32'h2AA);
    check("bp_count_b", 32'(count_out), 32'd5);
    check("bp_ready_in_back", {31'b0, ready_in}, 32'd1);
    @(posedge clk); #1;
    idle();

    // reset mid-word
    for (int i = 0; i < 3; i++) beat(2'h3, 1'b0);
    valid_in = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_valid_out", {31'b0, valid_out}, 32'd0);
    check("midrst_ready_in", {31'b0, ready_in}, 32'd1);
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) beat(2'h0, 1'b0);
    valid_in = 1'b0;
    @(negedge clk);
    check("midrst_valid", {31'b0, valid_out}, 32'd1);
    check("midrst_word", 32'(word_out), 32'h000);
    check("midrst_count", 32'(count_out), 32'd5);
    @(posedge clk); #1;

    // throughput with random gaps and random early last
    tp_phase = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 3) == 0) idle();
      beat(CW'($urandom_range(0, 3)), ($urandom_range(0, 6) == 0));
    end
    tp_phase = 1'b0;
    repeat (4) idle();
    check("tp_ready_in_stalls", 32'(tp_stalls), 32'd0);
    check("tp_all_words_out", 32'(q.size()), 32'd0);

    // non-divisible widths: 7-bit word from 3-bit chunks
    beat7(3'h5);
    beat7(3'h2);
    beat7(3'h7);
    v7 = 1'b0;
    @(negedge clk);
    check("nd_valid", {31'b0, vo7}, 32'd1);
    check("nd_word", 32'(wo7), 32'h55);
    check("nd_count", 32'(co7), 32'd3);
    @(posedge clk); #1;
    @(negedge clk);
    check("nd_drained", {31'b0, vo7}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
